// File: rtl/core_seq_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the core datapath.
// The master side is the sequencer; the slave side is the datapath/memory model.
interface core_seq_if #(
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic             ir_we;
    logic             dec_j;
    logic             dec_br;
    logic             dec_ld;
    logic             dec_st;
    logic             dec_alu_we;
    logic             br_taken;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             pc_we;
    logic             pc_sel;
    logic             halt;
    logic             fault;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
               pc_we, pc_sel, fault, instret, state,
        input  imem_ack, dec_j, dec_br, dec_ld, dec_st, dec_alu_we,
               br_taken, dmem_ack, halt
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
               pc_we, pc_sel, fault, instret, state,
        output imem_ack, dec_j, dec_br, dec_ld, dec_st, dec_alu_we,
               br_taken, dmem_ack, halt
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-timeout
// fault, halt at instruction boundary and a retired-instruction counter.
module core_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    core_seq_if.master bus
);
    localparam int  WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit  TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic mem_req;
    logic mem_ack;
    logic timeout_hit;

    assign mem_req     = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_ack     = (state_q == S_FETCH) ? bus.imem_ack : bus.dmem_ack;
    // wait_q counts earlier unacked cycles, so it equals MEM_TIMEOUT-1 in the last allowed cycle
    assign timeout_hit = TIMEOUT_EN && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack)  state_d = S_DECODE;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (bus.dec_ld || bus.dec_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.dmem_ack)  state_d = S_WB;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_WB:     state_d = bus.halt ? S_HALTED : S_FETCH;
            S_HALTED: state_d = bus.halt ? S_HALTED : S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FETCH;
        endcase

        // Any state change restarts the count, which covers entry into FETCH and MEM
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (TIMEOUT_EN && mem_req && !mem_ack)
            wait_d = wait_q + WAIT_W'(1);

        instret_d = (state_q == S_WB) ? instret_q + CNT_W'(1) : instret_q;
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 2'd0;
        bus.pc_we    = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.fault    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_we    = bus.imem_ack;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = bus.dec_st;
            end
            S_WB: begin
                bus.pc_we  = 1'b1;
                bus.pc_sel = bus.dec_j || (bus.dec_br && bus.br_taken);
                bus.rf_we  = bus.dec_alu_we || bus.dec_ld || bus.dec_j;
                if (bus.dec_j)       bus.wb_sel = 2'd2;
                else if (bus.dec_ld) bus.wb_sel = 2'd1;
            end
            S_FAULT: bus.fault = 1'b1;
            default: ;
        endcase
    end

    assign bus.instret = instret_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_core_seq.sv
// Randomized bench for core_seq: a per-instruction phase list derived from the
// sequencing rules predicts every cycle's state, enables and instret.
module tb_core_seq;
    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_seq_if #(.CNT_W(CNT_W)) bus ();

    core_seq #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int st;
        bit ack;
        bit hlt;
    } step_t;

    step_t            q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_instret;

    task automatic set_flags(input bit j, br, ld, st, alu, tk);
        bus.dec_j      = j;
        bus.dec_br     = br;
        bus.dec_ld     = ld;
        bus.dec_st     = st;
        bus.dec_alu_we = alu;
        bus.br_taken   = tk;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.halt     = 1'b0;
        set_flags(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_instret = '0;
        #1;
    endtask

    // One instruction: build the expected phase list, then replay it cycle by cycle.
    task automatic run_instr(input bit j, br, ld, st, alu, tk,
                             input int iw, input int dw, input bit halt_wb, input string name);
        step_t s;
        bit dead = 0;
        int nh;
        logic [13:0] exp_v, obs_v;
        logic [1:0]  wsel;
        q.delete();
        for (int k = 0; k <= iw && k < TO; k++) q.push_back('{0, k == iw, 0});
        if (iw >= TO) begin
            for (int k = 0; k < 4; k++) q.push_back('{6, 0, 0});
            dead = 1;
        end
        if (!dead) begin
            q.push_back('{1, 0, 0});
            q.push_back('{2, 0, 0});
            if (ld || st) begin
                for (int k = 0; k <= dw && k < TO; k++) q.push_back('{3, k == dw, 0});
                if (dw >= TO) begin
                    for (int k = 0; k < 4; k++) q.push_back('{6, 0, 0});
                    dead = 1;
                end
            end
        end
        if (!dead) begin
            q.push_back('{4, 0, halt_wb});
            if (halt_wb) begin
                nh = 2 + int'($urandom % 3);
                for (int k = 0; k < nh; k++) q.push_back('{5, 0, 1});
                q.push_back('{5, 0, 0});
            end
        end
        foreach (q[i]) begin
            s = q[i];
            set_flags(j, br, ld, st, alu, tk);
            bus.imem_ack = (s.st == 0) ? s.ack : 1'($urandom);
            bus.dmem_ack = (s.st == 3) ? s.ack : 1'($urandom);
            if (s.st == 4 || s.st == 5) bus.halt = s.hlt;
            else if (s.st == 2 && halt_wb) bus.halt = 1'b1;
            else bus.halt = 1'($urandom);
            #1;
            wsel  = (s.st != 4) ? 2'd0 : (j ? 2'd2 : (ld ? 2'd1 : 2'd0));
            exp_v = {3'(s.st), s.st == 0, s.st == 0 && s.ack, s.st == 3, s.st == 3 && st,
                     s.st == 4 && (alu || ld || j), wsel, s.st == 4,
                     s.st == 4 && (j || (br && tk)), s.st == 6};
            obs_v = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                     bus.rf_we, bus.wb_sel, bus.pc_we, bus.pc_sel, bus.fault};
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("FAIL %s step %0d outputs {state,ireq,irwe,dreq,dwe,rfwe,wbsel,pcwe,pcsel,fault}: got %b required %b",
                         name, i, obs_v, exp_v);
            end
            checks++;
            if (bus.instret !== exp_instret) begin
                failures++;
                $display("FAIL %s step %0d instret: got %0d required %0d", name, i, bus.instret, exp_instret);
            end
            if (s.st == 4) exp_instret = exp_instret + CNT_W'(1);
            @(negedge clk);
        end
        $display("txn %-10s flags j%0d br%0d ld%0d st%0d alu%0d tk%0d iw=%0d dw=%0d halt=%0d cycles=%0d",
                 name, j, br, ld, st, alu, tk, iw, dw, halt_wb, q.size());
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.state !== 3'd0 || bus.imem_req !== 1'b1 || bus.instret !== '0 || bus.fault !== 1'b0) begin
            failures++;
            $display("FAIL reset: state=%0d imem_req=%b instret=%0d fault=%b required 0,1,0,0",
                     bus.state, bus.imem_req, bus.instret, bus.fault);
        end
        $display("txn reset");
    endtask

    task automatic test_directed();
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, "add");
        run_instr(0, 0, 1, 0, 0, 0, 0, 2, 0, "lw_wait2");
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, "sw");
        run_instr(0, 1, 0, 0, 0, 1, 0, 0, 0, "beq_tk");
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 0, "beq_nt");
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, "jal");
        run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, "nop");
        run_instr(0, 0, 1, 0, 0, 0, TO - 1, TO - 1, 0, "ack_last");
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, TO, 0, 0, "imem_to");
        do_reset();
        checks++;
        if (bus.fault !== 1'b0 || bus.state !== 3'd0) begin
            failures++;
            $display("FAIL fault_clear: fault=%b state=%0d required 0,0", bus.fault, bus.state);
        end
        run_instr(0, 0, 0, 1, 0, 0, 1, TO, 0, "dmem_to");
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, 1, "halt_add");
        run_instr(0, 0, 1, 0, 0, 0, 1, 1, 1, "halt_lw");
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, "post_halt");
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 40; n++)
            run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                      ($urandom % 6) == 0, "rand");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 10; n++) run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, "b2b_add");
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        set_flags(0, 0, 1, 0, 0, 0);
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd3 || bus.dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_mem_entry: state=%0d dmem_req=%b required 3,1", bus.state, bus.dmem_req);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 3'd0 || bus.dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_mem_reset: state=%0d dmem_req=%b required 0,0", bus.state, bus.dmem_req);
        end
        rst_n = 1'b1;
        $display("txn reset_mid_mem");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.halt     = 1'b0;
        set_flags(0, 0, 0, 0, 0, 0);
        exp_instret = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_timeout();
        test_halt();
        test_random();
        test_back_to_back();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
